seq_ser: RTL and testbench
==========================

SEQ_SER -- requirements
Module: seq_ser

Interface
REQ-001 Parameter: DW, default 8, data word width in bits; legal range 2..32.
REQ-002 Parameter: IDLE_BIT, default 0, value driven on seq_out while no frame is being sent.
REQ-003 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  synchronous reset, active-high.
REQ-006 Port: din  input  DW  parallel word to serialize.
REQ-007 Port: din_valid  input  1  din holds a word to send.
REQ-008 Port: din_ready  output  1  block accepts din this cycle.
REQ-009 Port: seq_out  output  1  serial bit stream, MSB first; feeds the sequence detector's seq_in.
REQ-010 Port: seq_valid  output  1  seq_out carries a frame bit this cycle.
REQ-011 Port: frame_done  output  1  one-cycle pulse on the last bit of a frame.
REQ-012 Port: frame_cnt  output  16  count of completed frames, wraps 16'hFFFF -> 0.

Function
REQ-013 The module SHALL transfer a word only on a rising edge where din_valid && din_ready is true; din is ignored otherwise.
REQ-014 The FSM SHALL have states IDLE, SHIFT and, when SER_PARITY_EN is defined, PAR.
REQ-015 IDLE: din_ready=1, seq_valid=0, seq_out=IDLE_BIT; on transfer, go to SHIFT.
REQ-016 On transfer, the module SHALL load din into a DW-bit shift register and set bit_cnt=DW-1.
REQ-017 The first bit, din[DW-1], SHALL appear on seq_out in the cycle after the transfer edge (latency 1), with seq_valid=1.
REQ-018 SHIFT: one bit per cycle, MSB first; bit_cnt decrements each cycle; seq_out and seq_valid are registered outputs.
REQ-019 Last-bit cycle: the cycle with bit_cnt==0 in SHIFT without parity, or the PAR cycle with parity.
REQ-020 In the last-bit cycle, din_ready SHALL be 1; in all other SHIFT and PAR cycles it SHALL be 0.
REQ-021 A transfer in the last-bit cycle SHALL start the next frame in the next cycle with no gap; seq_valid stays 1.
REQ-022 With no transfer in the last-bit cycle, the FSM SHALL return to IDLE; seq_out=IDLE_BIT and seq_valid=0 from the next cycle.
REQ-023 frame_done SHALL be 1 exactly in each last-bit cycle and 0 otherwise.
REQ-024 frame_cnt SHALL increment by 1 on the edge that ends each last-bit cycle, including back-to-back frames.
REQ-025 A word is never dropped: din_valid held high with din_ready low SHALL be accepted at the next last-bit cycle or in IDLE.

Reset
REQ-026 While rst=1 at a rising edge, the module SHALL enter IDLE with: din_ready=1, seq_out=IDLE_BIT, seq_valid=0, frame_done=0, frame_cnt=0, shift register=0, bit_cnt=0.
REQ-027 Reset mid-frame SHALL abandon the frame without a frame_done pulse or frame_cnt increment; a concurrent transfer is discarded.

Configuration
REQ-028 Macro SER_PARITY_EN: when defined, after the DW data bits the FSM SHALL enter PAR for one cycle and drive even parity (XOR of the DW data bits) on seq_out with seq_valid=1.
REQ-029 With SER_PARITY_EN defined, a frame SHALL be DW+1 cycles long, and frame_done/din_ready apply to the PAR cycle.
REQ-030 With SER_PARITY_EN undefined, no PAR state or parity logic SHALL exist, and a frame SHALL be DW cycles long.

Verification
REQ-031 Bench SHALL cover: DW=8, no parity, din=8'hB4 single transfer -> seq_out 1,0,1,1,0,1,0,0 on cycles 1..8 after transfer, seq_valid=1 for those cycles, frame_done on cycle 8, frame_cnt=1, then seq_out=0, seq_valid=0.
REQ-032 Bench SHALL cover: back-to-back 8'hB4 then 8'h5A with din_valid held -> 16 consecutive seq_valid=1 cycles, bits 10110100 01011010, din_ready high only in cycles 8 and 16, frame_cnt=2.
REQ-033 Bench SHALL cover: SER_PARITY_EN defined, din=8'hB4 -> 9 bits 1,0,1,1,0,1,0,0,0, frame_done on cycle 9; din=8'h01 -> parity bit 1.
REQ-034 Bench SHALL cover: rst asserted on cycle 4 of a frame -> next cycle seq_valid=0, seq_out=IDLE_BIT, frame_cnt unchanged, no frame_done pulse.
REQ-035 Bench SHALL cover: frame_cnt preloaded to 16'hFFFF by sending 65535 frames, then one more frame -> frame_cnt=0.
REQ-036 Bench SHALL cover: seq_out driving a 1011010 sequence detector with din=8'hB4 -> the detector raises its match flag exactly once.

Source files
------------

// File: rtl/seq_ser_if.sv
// Parallel-in / serial-out handshake bundle for seq_ser.
interface seq_ser_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          seq_out;
    logic          seq_valid;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  seq_out,
        input  seq_valid,
        input  frame_done,
        input  frame_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output seq_out,
        output seq_valid,
        output frame_done,
        output frame_cnt
    );
endinterface

// File: rtl/seq_ser.sv
// MSB-first word serializer with back-to-back framing and a wrapping frame counter.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module seq_ser #(
    parameter int unsigned DW       = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    seq_ser_if.slave bus
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

    state_t          r_state;
    logic [DW-1:0]   r_shift;
    logic [CW-1:0]   r_bit_cnt;
    logic            r_seq_out;
    logic            r_seq_valid;
    logic            r_din_ready;
    logic            r_frame_done;
    logic [15:0]     r_frame_cnt;

    state_t          w_state_nxt;
    logic [DW-1:0]   w_shift_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_load;
    logic            w_xfer;
    logic            w_seq_out_nxt;
    logic            w_seq_valid_nxt;
    logic            w_din_ready_nxt;
    logic            w_frame_done_nxt;

`ifdef SER_PARITY_EN
    logic            r_par;
    logic            w_par_nxt;
`endif

    assign w_xfer = bus.din_valid && r_din_ready;

    // Next-state logic; registered outputs are derived from the next state
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_bit_cnt;
        w_load           = 1'b0;
        w_seq_out_nxt    = IDLE_BIT;
        w_seq_valid_nxt  = 1'b0;
        w_din_ready_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_shift_nxt = {r_shift[DW-2:0], 1'b0};
                    w_cnt_nxt   = r_bit_cnt - CW'(1);
                end else begin
`ifdef SER_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    if (w_xfer) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_shift_nxt = '0;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_shift_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_shift_nxt = bus.din;
            w_cnt_nxt   = CNT_LAST;
        end

        case (w_state_nxt)
            S_SHIFT: begin
                w_seq_out_nxt   = w_shift_nxt[DW-1];
                w_seq_valid_nxt = 1'b1;
`ifndef SER_PARITY_EN
                w_frame_done_nxt = (w_cnt_nxt == '0);
                w_din_ready_nxt  = (w_cnt_nxt == '0);
`endif
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                w_seq_out_nxt    = w_par_nxt;
                w_seq_valid_nxt  = 1'b1;
                w_frame_done_nxt = 1'b1;
                w_din_ready_nxt  = 1'b1;
            end
`endif
            default: begin
                w_din_ready_nxt = 1'b1;
            end
        endcase
    end

`ifdef SER_PARITY_EN
    // Parity is captured with the word so the trailer does not need the shifted data
    assign w_par_nxt = w_load ? (^bus.din) : r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_seq_out    <= IDLE_BIT;
            r_seq_valid  <= 1'b0;
            r_din_ready  <= 1'b1;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_seq_out    <= w_seq_out_nxt;
            r_seq_valid  <= w_seq_valid_nxt;
            r_din_ready  <= w_din_ready_nxt;
            r_frame_done <= w_frame_done_nxt;
            // r_frame_done marks the last-bit cycle, so the count steps on its closing edge
            r_frame_cnt  <= r_frame_cnt + 16'(r_frame_done);
        end
    end

    assign bus.din_ready  = r_din_ready;
    assign bus.seq_out    = r_seq_out;
    assign bus.seq_valid  = r_seq_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_seq_ser.sv
// Scoreboard bench for seq_ser: expected bits queued on each accepted word, compared as they emerge.
module tb_seq_ser;

`ifdef SER_PARITY_EN
    localparam int FL  = 9;
    localparam int FL2 = 3;
`else
    localparam int FL  = 8;
    localparam int FL2 = 2;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk2 = 1'b0;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;
    always #1 clk2 = ~clk2;

    seq_ser_if #(.DW(8)) bus ();
    seq_ser_if #(.DW(2)) wbus ();

    seq_ser #(.DW(8), .IDLE_BIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_ser #(.DW(2), .IDLE_BIT(1'b0)) u_wrap (
        .clk (clk2),
        .rst (rst2),
        .bus (wbus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit_t        sb[$];
    logic        exp_ready = 1'b1;
    logic [15:0] exp_cnt = 16'h0;

    logic [31:0] cap_bits, cap_rdy, cap_done;
    int          cap_n, run, max_run, det_hits;
    logic [6:0]  det;

    logic        wrap_done = 1'b0;
    logic [15:0] wrap_ff, wrap_zero;
    int          wrap_frames;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cap_clear();
        cap_bits = '0; cap_rdy = '0; cap_done = '0;
        cap_n = 0; run = 0; max_run = 0; det_hits = 0; det = '0;
    endtask

    // Compare one output cycle against the scoreboard head
    task automatic observe();
        bit_t e;
        check_eq("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("seq_valid", 32'(bus.seq_valid), 32'd1);
            check_eq("seq_out", 32'(bus.seq_out), 32'(e.b));
            check_eq("frame_done", 32'(bus.frame_done), 32'(e.last));
            exp_ready = e.last;
            if (e.last) exp_cnt = exp_cnt + 16'd1;
        end else begin
            check_eq("idle_valid", 32'(bus.seq_valid), 32'd0);
            check_eq("idle_out", 32'(bus.seq_out), 32'd0);
            check_eq("idle_done", 32'(bus.frame_done), 32'd0);
            exp_ready = 1'b1;
        end
        check_eq("din_ready", 32'(bus.din_ready), 32'(exp_ready));
        if (bus.seq_valid) begin
            cap_bits = {cap_bits[30:0], bus.seq_out};
            cap_rdy  = {cap_rdy[30:0], bus.din_ready};
            cap_done = {cap_done[30:0], bus.frame_done};
            cap_n++;
            run++;
            if (run > max_run) max_run = run;
            det = {det[5:0], bus.seq_out};
            if (det == 7'b1011010) det_hits++;
        end else begin
            run = 0;
        end
    endtask

    // Drive inputs for the coming edge, update the model, then observe the resulting cycle
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
        bus.din_valid = v;
        bus.din       = d;
        rst           = r;
        acc           = 1'b0;
        if (r) begin
            sb.delete();
            exp_cnt = 16'h0;
        end else if (v && exp_ready) begin
            acc = 1'b1;
            for (int i = 7; i >= 0; i--)
                sb.push_back('{b: d[i], last: (i == 0) && (FL == 8)});
            if (FL == 9) sb.push_back('{b: ^d, last: 1'b1});
        end
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(1'b0, 8'h00, 1'b0, acc);
        check_eq("drain", 32'(sb.size()), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Wrap instance: back-to-back frames until the counter rolls over
    initial begin
        int cyc;
        wbus.din_valid = 1'b0;
        wbus.din       = 2'b10;
        wrap_frames    = 0;
        wrap_ff        = '0;
        wrap_zero      = 16'h1234;
        repeat (2) @(posedge clk2);
        @(negedge clk2);
        rst2 = 1'b0;
        wbus.din_valid = 1'b1;
        cyc = 0;
        while (wrap_frames < 65535 && cyc < 300000) begin
            @(negedge clk2);
            cyc++;
            if (wbus.frame_done) wrap_frames++;
        end
        @(negedge clk2);
        wrap_ff = wbus.frame_cnt;
        while (!wbus.frame_done && cyc < 300000) begin
            @(negedge clk2);
            cyc++;
        end
        @(negedge clk2);
        wrap_zero = wbus.frame_cnt;
        wbus.din_valid = 1'b0;
        wrap_done = 1'b1;
    end

    initial begin
        logic acc;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        cap_clear();

        // Reset state
        cycle(1'b0, 8'h00, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, acc);
        check_eq("rst_ready", 32'(bus.din_ready), 32'd1);
        check_eq("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, acc);

        // Single B4 frame, also feeding the 1011010 detector
        cap_clear();
        cycle(1'b1, 8'hB4, 1'b0, acc);
        drain();
        check_eq("b4_len", 32'(cap_n), 32'(FL));
        check_eq("b4_cnt", 32'(bus.frame_cnt), 32'd1);
        check_eq("det_hits", 32'(det_hits), 32'd1);
`ifdef SER_PARITY_EN
        check_eq("b4_bits", cap_bits, 32'b101101000);
        check_eq("b4_done", cap_done, 32'b000000001);
`else
        check_eq("b4_bits", cap_bits, 32'hB4);
        check_eq("b4_done", cap_done, 32'b00000001);
`endif

        // Back-to-back B4 then 5A with valid held
        cap_clear();
        cycle(1'b1, 8'hB4, 1'b0, acc);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) cycle(1'b1, 8'h5A, 1'b0, acc);
        check_eq("b2b_accept", 32'(acc), 32'd1);
        drain();
        check_eq("b2b_run", 32'(max_run), 32'(2 * FL));
        check_eq("b2b_cnt", 32'(bus.frame_cnt), 32'd3);
`ifdef SER_PARITY_EN
        check_eq("b2b_bits", cap_bits, 32'b101101000010110100);
        check_eq("b2b_rdy", cap_rdy, 32'b000000001000000001);
`else
        check_eq("b2b_bits", cap_bits, 32'hB45A);
        check_eq("b2b_rdy", cap_rdy, 32'h0101);
`endif

        // Single 01 frame: parity trailer is 1
        cap_clear();
        cycle(1'b1, 8'h01, 1'b0, acc);
        drain();
`ifdef SER_PARITY_EN
        check_eq("p01_bits", cap_bits, 32'b000000011);
`else
        check_eq("p01_bits", cap_bits, 32'h01);
`endif

        // Reset during cycle 4 of a frame
        cycle(1'b0, 8'h00, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 8'hB4, 1'b0, acc);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 8'hFF, 1'b1, acc);
        check_eq("mid_rst_valid", 32'(bus.seq_valid), 32'd0);
        check_eq("mid_rst_cnt", 32'(bus.frame_cnt), 32'd0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, acc);

        // Counter rollover on the DW=2 instance
        for (int i = 0; i < 500000 && !wrap_done; i++) @(posedge clk2);
        check_eq("wrap_done", 32'(wrap_done), 32'd1);
        check_eq("wrap_ffff", 32'(wrap_ff), 32'h0000FFFF);
        check_eq("wrap_zero", 32'(wrap_zero), 32'd0);
        check_eq("wrap_len", 32'(FL2), 32'(FL - 6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
